mor1kx_tcm_arbiter_prontoespresso: RTL and testbench
====================================================

Name: mor1kx_tcm_arbiter_prontoespresso

Overview:
Shares one single-port, single-cycle TCM (read data registered one cycle after enable) between the pronto espresso fetch unit (ibus, read-only) and the LSU (dbus, read/write). The block grants one access per cycle, routes acknowledges and read data back one cycle later, and prevents ibus starvation with a bounded dbus-streak counter. It sits between the fetch/LSU bus ports and the TCM macro.

Parameters:
OPTION_OPERAND_WIDTH, 32, bus address/data width
OPTION_TCM_ADDR_WIDTH, 12, log2 of TCM depth in 32-bit words
OPTION_TCM_BASE, 32'h0, byte base address of TCM window
OPTION_DBUS_MAX_STREAK, 4, max consecutive dbus grants while ibus is pending (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ibus_adr_i  in  32  fetch byte address
ibus_req_i  in  1  fetch request (level, one access per granted cycle)
ibus_ack_o  out  1  fetch ack, aligned with ibus_dat_o
ibus_err_o  out  1  fetch error
ibus_dat_o  out  32  fetch read data
dbus_adr_i  in  32  LSU byte address
dbus_req_i  in  1  LSU request
dbus_we_i  in  1  LSU write enable
dbus_bsel_i  in  4  LSU byte selects
dbus_dat_i  in  32  LSU write data
dbus_ack_o  out  1  LSU ack
dbus_err_o  out  1  LSU error
dbus_dat_o  out  32  LSU read data
mem_adr_o  out  OPTION_TCM_ADDR_WIDTH  TCM word address
mem_en_o  out  1  TCM enable
mem_we_o  out  1  TCM write
mem_bsel_o  out  4  TCM byte write enables
mem_dat_o  out  32  TCM write data
mem_dat_i  in  32  TCM read data (valid cycle after mem_en_o)

Behaviour:
- Reset (rst low, async): ack/err outputs 0, owner_r=0, resp_v_r=0, streak=0; mem_en_o and mem_we_o forced 0 while rst low.
- Grant (combinational, cycle N): dbus_req_i & !(ibus_req_i & streak==OPTION_DBUS_MAX_STREAK) -> dbus; else ibus_req_i -> ibus; else none.
- Memory drive in N: mem_en_o=1 on any grant; mem_adr_o=granted adr[OPTION_TCM_ADDR_WIDTH+1:2]; mem_we_o=dbus_we_i & dbus granted; mem_bsel_o=dbus_bsel_i if dbus write else 0; mem_dat_o=dbus_dat_i.
- Response in N+1: registered owner_r/resp_v_r; granted side's ack=1; ibus_dat_o/dbus_dat_o = mem_dat_i (both buses see mem_dat_i; only ack qualifies). Writes also ack in N+1. Latency fixed at 1 cycle; never any ack without a prior grant.
- Back-to-back: a request held high in N+1 is a new access; requester presents the next address in the ack cycle. Full throughput 1 access/cycle.
- Non-granted requester sees no ack; it must hold req/adr until acked.
- Streak counter: +1 (saturating at OPTION_DBUS_MAX_STREAK) on each dbus grant while ibus_req_i=1; cleared on an ibus grant or any cycle with ibus_req_i=0. On reaching max with both pending, the next grant goes to ibus and the counter clears.
- Simultaneous first requests: dbus wins (streak starts at 0).
- Requester dropping req after a grant still receives its ack in N+1.
- Reset asserted mid-access: pending ack is discarded; no ack after reset release.

Optional Feature:
MOR1KX_TCM_ARB_RANGE_CHECK_EN: when defined, a granted address outside [OPTION_TCM_BASE, OPTION_TCM_BASE + 4*2^OPTION_TCM_ADDR_WIDTH) produces no memory enable/write; the granted side gets err=1, ack=0 in N+1, and the grant still counts toward the streak. When undefined, the upper address bits are ignored (the window aliases), and err outputs are tied 0.

Test Plan:
1. ibus_req held, adr 0x100,0x104,0x108 advanced on each ack -> ibus_ack_o=1 on every cycle from N+1, mem_adr_o=0x40,0x41,0x42, data matches the preloaded words.
2. dbus write adr 0x20 bsel 4'b0011 dat 0xDEADBEEF, then read 0x20 (word preloaded 0x11223344) -> dbus_ack_o each N+1, read returns 0x1122BEEF.
3. Both requests held continuously, MAX_STREAK=4 -> grant pattern D,D,D,D,I repeating; ibus gets exactly 1 ack per 5 cycles.
4. Same cycle single ibus and dbus read requests, then dbus drops -> dbus acked in N+1, ibus acked in N+2, no double ack.
5. With MOR1KX_TCM_ARB_RANGE_CHECK_EN, TCM_ADDR_WIDTH=12, dbus read at 0x4000 -> mem_en_o=0, dbus_err_o=1, dbus_ack_o=0 in N+1.
6. Assert rst low in the cycle after an ibus grant -> ibus_ack_o=0 during and after reset, and all outputs at reset values.

Source files
------------

// File: rtl/mor1kx_tcm_arbiter_prontoespresso.sv
// mor1kx_tcm_arbiter_prontoespresso
//
// Shares one single-port TCM between the pronto espresso fetch unit (ibus,
// read-only) and the LSU (dbus, read/write). At most one access is granted
// per cycle. The TCM returns read data one cycle after enable, so the
// acknowledge and read data reach the granted side in the following cycle.
// dbus normally wins. A streak counter bounds how many consecutive dbus
// grants can be issued while ibus is waiting, so ibus cannot starve.
//
// Optional build macro: MOR1KX_TCM_ARB_RANGE_CHECK_EN
//   defined   : a granted access outside the TCM window is not issued to the
//               memory. The granted side gets err instead of ack.
//   undefined : upper address bits are ignored (the window aliases), and the
//               err outputs are tied low.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   ibus_*            fetch port: adr/req in; ack/err/dat out
//   dbus_*            LSU port: adr/req/we/bsel/dat in; ack/err/dat out
//   mem_*             TCM port: adr/en/we/bsel/dat out; mem_dat_i read data in
module mor1kx_tcm_arbiter_prontoespresso #(
  parameter int unsigned OPTION_OPERAND_WIDTH   = 32,
  parameter int unsigned OPTION_TCM_ADDR_WIDTH  = 12,
  parameter logic [31:0] OPTION_TCM_BASE        = 32'h0,
  parameter int unsigned OPTION_DBUS_MAX_STREAK = 4
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [OPTION_OPERAND_WIDTH-1:0]  ibus_adr_i,
  input  logic                             ibus_req_i,
  output logic                             ibus_ack_o,
  output logic                             ibus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  ibus_dat_o,

  input  logic [OPTION_OPERAND_WIDTH-1:0]  dbus_adr_i,
  input  logic                             dbus_req_i,
  input  logic                             dbus_we_i,
  input  logic [3:0]                       dbus_bsel_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  dbus_dat_i,
  output logic                             dbus_ack_o,
  output logic                             dbus_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  dbus_dat_o,

  output logic [OPTION_TCM_ADDR_WIDTH-1:0] mem_adr_o,
  output logic                             mem_en_o,
  output logic                             mem_we_o,
  output logic [3:0]                       mem_bsel_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  mem_dat_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  mem_dat_i
);

  localparam int unsigned W  = OPTION_OPERAND_WIDTH;
  localparam int unsigned AW = OPTION_TCM_ADDR_WIDTH;
  localparam logic [3:0]  MAX_STREAK = 4'(OPTION_DBUS_MAX_STREAK);

  logic         grant_d;
  logic         grant_i;
  logic         grant_any;
  logic [W-1:0] gnt_adr;
  logic         addr_ok;
  logic [3:0]   streak;
  logic [3:0]   streak_nxt;

  // Response-cycle state: owner_r = 1 means dbus owns the response.
  logic         owner_r;
  logic         resp_v_r;
  logic         err_r;

  // dbus has priority unless ibus has waited through a full dbus streak.
  assign grant_d   = dbus_req_i & ~(ibus_req_i & (streak == MAX_STREAK));
  assign grant_i   = ibus_req_i & ~grant_d;
  assign grant_any = grant_d | grant_i;
  assign gnt_adr   = grant_d ? dbus_adr_i : ibus_adr_i;

`ifdef MOR1KX_TCM_ARB_RANGE_CHECK_EN
  // Subtracting the base first makes the compare wrap-safe. The address is
  // inside the window when every offset bit above the word index is clear.
  logic [W-1:0] win_off;
  assign win_off = gnt_adr - W'(OPTION_TCM_BASE);
  assign addr_ok = (win_off[W-1:AW+2] == '0);
`else
  assign addr_ok = 1'b1;
`endif

  // The enables are qualified with rst so the TCM stays idle during reset.
  assign mem_en_o   = rst & grant_any & addr_ok;
  assign mem_we_o   = rst & grant_d & dbus_we_i & addr_ok;
  assign mem_adr_o  = gnt_adr[AW+1:2];
  assign mem_bsel_o = mem_we_o ? dbus_bsel_i : '0;
  assign mem_dat_o  = dbus_dat_i;

  // Counting happens only while ibus is waiting. Any ibus grant or idle
  // ibus cycle restarts the streak.
  always_comb begin
    streak_nxt = streak;
    if (!ibus_req_i || grant_i)
      streak_nxt = '0;
    else if (grant_d && (streak != MAX_STREAK))
      streak_nxt = streak + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r  <= 1'b0;
      resp_v_r <= 1'b0;
      err_r    <= 1'b0;
      streak   <= '0;
    end else begin
      owner_r  <= grant_d;
      resp_v_r <= grant_any;
      err_r    <= grant_any & ~addr_ok;
      streak   <= streak_nxt;
    end
  end

  assign ibus_ack_o = resp_v_r & ~owner_r & ~err_r;
  assign dbus_ack_o = resp_v_r &  owner_r & ~err_r;

`ifdef MOR1KX_TCM_ARB_RANGE_CHECK_EN
  assign ibus_err_o = resp_v_r & ~owner_r & err_r;
  assign dbus_err_o = resp_v_r &  owner_r & err_r;
`else
  assign ibus_err_o = 1'b0;
  assign dbus_err_o = 1'b0;
`endif

  // Both buses see the TCM read data. Only the ack tells a bus the data is its own.
  assign ibus_dat_o = mem_dat_i;
  assign dbus_dat_o = mem_dat_i;

  // Byte-offset bits, and upper bits when the window aliases, are not decoded.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{ibus_adr_i, dbus_adr_i};

endmodule

// File: tb/tb_mor1kx_tcm_arbiter_prontoespresso.sv
module tb_mor1kx_tcm_arbiter_prontoespresso;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ibus_adr_i;
  logic        ibus_req_i;
  logic        ibus_ack_o, ibus_err_o;
  logic [31:0] ibus_dat_o;
  logic [31:0] dbus_adr_i;
  logic        dbus_req_i, dbus_we_i;
  logic [3:0]  dbus_bsel_i;
  logic [31:0] dbus_dat_i;
  logic        dbus_ack_o, dbus_err_o;
  logic [31:0] dbus_dat_o;
  logic [11:0] mem_adr_o;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_bsel_o;
  logic [31:0] mem_dat_o;
  logic [31:0] mem_dat_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mor1kx_tcm_arbiter_prontoespresso #(
    .OPTION_OPERAND_WIDTH  (32),
    .OPTION_TCM_ADDR_WIDTH (12),
    .OPTION_TCM_BASE       (32'h0),
    .OPTION_DBUS_MAX_STREAK(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ibus_adr_i (ibus_adr_i),
    .ibus_req_i (ibus_req_i),
    .ibus_ack_o (ibus_ack_o),
    .ibus_err_o (ibus_err_o),
    .ibus_dat_o (ibus_dat_o),
    .dbus_adr_i (dbus_adr_i),
    .dbus_req_i (dbus_req_i),
    .dbus_we_i  (dbus_we_i),
    .dbus_bsel_i(dbus_bsel_i),
    .dbus_dat_i (dbus_dat_i),
    .dbus_ack_o (dbus_ack_o),
    .dbus_err_o (dbus_err_o),
    .dbus_dat_o (dbus_dat_o),
    .mem_adr_o  (mem_adr_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_bsel_o (mem_bsel_o),
    .mem_dat_o  (mem_dat_o),
    .mem_dat_i  (mem_dat_i)
  );

  // TCM model: byte-masked write, read data registered one cycle after enable.
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_bsel_o[b]) mem[mem_adr_o][b*8 +: 8] <= mem_dat_o[b*8 +: 8];
      end
      mem_dat_i <= mem[mem_adr_o];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iadr,
                       input logic dreq, input logic dwe, input logic [31:0] dadr,
                       input logic [3:0] dbsel, input logic [31:0] ddat);
    ibus_req_i  = ireq;
    ibus_adr_i  = iadr;
    dbus_req_i  = dreq;
    dbus_we_i   = dwe;
    dbus_adr_i  = dadr;
    dbus_bsel_i = dbsel;
    dbus_dat_i  = ddat;
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iadr;
    logic        dreq;
    logic        dwe;
    logic [31:0] dadr;
    logic [3:0]  dbsel;
    logic [31:0] ddat;
    logic        men;
    logic [11:0] madr;
    logic        mwe;
    logic [3:0]  mbsel;
    logic        iack;   // ack for the previous row's grant
    logic        dack;
    logic        chk_dat;
    logic [31:0] edat;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(logic ireq, logic [31:0] iadr, logic dreq, logic dwe,
                              logic [31:0] dadr, logic [3:0] dbsel, logic [31:0] ddat,
                              logic men, logic [11:0] madr, logic mwe, logic [3:0] mbsel,
                              logic iack, logic dack, logic chk_dat, logic [31:0] edat);
    vec_t v;
    v.ireq = ireq; v.iadr = iadr; v.dreq = dreq; v.dwe = dwe; v.dadr = dadr;
    v.dbsel = dbsel; v.ddat = ddat; v.men = men; v.madr = madr; v.mwe = mwe;
    v.mbsel = mbsel; v.iack = iack; v.dack = dack; v.chk_dat = chk_dat; v.edat = edat;
    return v;
  endfunction

  int iack_cnt;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | i;
    mem[8] = 32'h1122_3344;
    mem_dat_i = '0;

    //            ireq iadr     dreq we dadr     bsel  ddat          men madr    we bsel iack dack cd edat
    // ibus stream with the address advanced in each ack cycle
    vecs[0] = mk(1, 32'h100, 0, 0, 32'h0,  4'h0, 32'h0,        1, 12'h040, 0, 4'h0, 0, 0, 0, 32'h0);
    vecs[1] = mk(1, 32'h104, 0, 0, 32'h0,  4'h0, 32'h0,        1, 12'h041, 0, 4'h0, 1, 0, 1, 32'hA000_0040);
    vecs[2] = mk(1, 32'h108, 0, 0, 32'h0,  4'h0, 32'h0,        1, 12'h042, 0, 4'h0, 1, 0, 1, 32'hA000_0041);
    vecs[3] = mk(0, 32'h0,   0, 0, 32'h0,  4'h0, 32'h0,        0, 12'h000, 0, 4'h0, 1, 0, 1, 32'hA000_0042);
    // dbus partial write then read-back
    vecs[4] = mk(0, 32'h0,   1, 1, 32'h20, 4'h3, 32'hDEADBEEF, 1, 12'h008, 1, 4'h3, 0, 0, 0, 32'h0);
    vecs[5] = mk(0, 32'h0,   1, 0, 32'h20, 4'hF, 32'h0,        1, 12'h008, 0, 4'h0, 0, 1, 0, 32'h0);
    vecs[6] = mk(0, 32'h0,   0, 0, 32'h0,  4'h0, 32'h0,        0, 12'h000, 0, 4'h0, 0, 1, 1, 32'h1122_BEEF);
    // simultaneous requests: dbus first, ibus next cycle
    vecs[7] = mk(1, 32'h200, 1, 0, 32'h40, 4'h0, 32'h0,        1, 12'h010, 0, 4'h0, 0, 0, 0, 32'h0);
    vecs[8] = mk(1, 32'h200, 0, 0, 32'h0,  4'h0, 32'h0,        1, 12'h080, 0, 4'h0, 0, 1, 1, 32'hA000_0010);
    vecs[9] = mk(0, 32'h0,   0, 0, 32'h0,  4'h0, 32'h0,        0, 12'h000, 0, 4'h0, 1, 0, 1, 32'hA000_0080);

    // Reset state, with an ibus request already present
    rst = 1'b0;
    drive(1, 32'h100, 1, 1, 32'h0, 4'hF, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    chk("rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_acks",   32'({ibus_ack_o, dbus_ack_o, ibus_err_o, dbus_err_o}), 32'd0);
    drive(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].ireq, vecs[i].iadr, vecs[i].dreq, vecs[i].dwe,
            vecs[i].dadr, vecs[i].dbsel, vecs[i].ddat);
      #1;
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en_o), 32'(vecs[i].men));
      if (vecs[i].men) begin
        chk($sformatf("v%0d_mem_adr", i),  32'(mem_adr_o),  32'(vecs[i].madr));
        chk($sformatf("v%0d_mem_we", i),   32'(mem_we_o),   32'(vecs[i].mwe));
        chk($sformatf("v%0d_mem_bsel", i), 32'(mem_bsel_o), 32'(vecs[i].mbsel));
      end
      chk($sformatf("v%0d_ibus_ack", i), 32'(ibus_ack_o), 32'(vecs[i].iack));
      chk($sformatf("v%0d_dbus_ack", i), 32'(dbus_ack_o), 32'(vecs[i].dack));
      if (vecs[i].chk_dat && vecs[i].iack) chk($sformatf("v%0d_ibus_dat", i), ibus_dat_o, vecs[i].edat);
      if (vecs[i].chk_dat && vecs[i].dack) chk($sformatf("v%0d_dbus_dat", i), dbus_dat_o, vecs[i].edat);
    end

    // Both held continuously: D,D,D,D,I repeating
    iack_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1, 32'h300, 1, 0, 32'h400, 4'h0, 32'h0);
      #1;
      chk($sformatf("s%0d_mem_adr", k), 32'(mem_adr_o), (k % 5 == 4) ? 32'h0C0 : 32'h100);
      chk($sformatf("s%0d_ibus_ack", k), 32'(ibus_ack_o), 32'((k >= 1) && ((k - 1) % 5 == 4)));
      chk($sformatf("s%0d_dbus_ack", k), 32'(dbus_ack_o), 32'((k >= 1) && ((k - 1) % 5 != 4)));
      if (ibus_ack_o) iack_cnt++;
    end
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("s_drain_ibus_ack", 32'(ibus_ack_o), 32'd1);
    chk("s_drain_dbus_ack", 32'(dbus_ack_o), 32'd0);
    if (ibus_ack_o) iack_cnt++;
    chk("s_ibus_ack_count", 32'(iack_cnt), 32'd4);

    // Address beyond the 16 KiB window
    @(negedge clk);
    drive(0, 32'h0, 1, 0, 32'h4000, 4'h0, 32'h0);
    #1;
`ifdef MOR1KX_TCM_ARB_RANGE_CHECK_EN
    chk("oor_mem_en", 32'(mem_en_o), 32'd0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("oor_dbus_err", 32'(dbus_err_o), 32'd1);
    chk("oor_dbus_ack", 32'(dbus_ack_o), 32'd0);
`else
    chk("alias_mem_en",  32'(mem_en_o),  32'd1);
    chk("alias_mem_adr", 32'(mem_adr_o), 32'd0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("alias_dbus_ack", 32'(dbus_ack_o), 32'd1);
    chk("alias_dbus_err", 32'(dbus_err_o), 32'd0);
`endif

    // Reset in the cycle after an ibus grant discards the pending ack
    @(negedge clk);
    drive(1, 32'h100, 0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_ibus_ack", 32'(ibus_ack_o), 32'd0);
    chk("mrst_mem_en",   32'(mem_en_o),   32'd0);
    chk("mrst_outs",     32'({dbus_ack_o, ibus_err_o, dbus_err_o, mem_we_o}), 32'd0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    #1;
    chk("mrst_rel_ibus_ack", 32'(ibus_ack_o), 32'd0);
    @(negedge clk); #1;
    chk("mrst_post_ibus_ack", 32'(ibus_ack_o), 32'd0);
    chk("mrst_post_dbus_ack", 32'(dbus_ack_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
